// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-register taps and control outputs shared between the datapath and the hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_reg_write;
    logic [DATA_W-1:0] mem_data;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_reg_write;
    logic [DATA_W-1:0] wb_data;
    logic              branch_taken;

    logic [1:0]        forward_a;
    logic [1:0]        forward_b;
    logic [DATA_W-1:0] alu_in_a;
    logic [DATA_W-1:0] alu_in_b;
    logic              pc_write;
    logic              if_id_write;
    logic              id_ex_bubble;
    logic              if_id_flush;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, ex_rs, ex_rt, ex_rd, ex_mem_read,
               ex_rs_data, ex_rt_data, mem_rd, mem_reg_write, mem_data,
               wb_rd, wb_reg_write, wb_data, branch_taken,
        input  forward_a, forward_b, alu_in_a, alu_in_b, pc_write,
               if_id_write, id_ex_bubble, if_id_flush, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, ex_rs, ex_rt, ex_rd, ex_mem_read,
               ex_rs_data, ex_rt_data, mem_rd, mem_reg_write, mem_data,
               wb_rd, wb_reg_write, wb_data, branch_taken,
        output forward_a, forward_b, alu_in_a, alu_in_b, pc_write,
               if_id_write, id_ex_bubble, if_id_flush, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for the 5-stage core: operand forwarding, load-use stall sequencing,
// taken-branch flush sequencing and saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int DATA_W      = 16,
    parameter int REG_AW      = 4,
    parameter int ZERO_REG    = 0,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 16
) (
    input logic                   clk_i,
    input logic                   reset_n_i,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int SRW = $clog2(LOAD_LAT + 1);
    localparam int FRW = $clog2(FLUSH_DEPTH + 1);
    localparam logic [REG_AW-1:0] ZERO         = REG_AW'(ZERO_REG);
    localparam logic [SRW-1:0]    STALL_RELOAD = SRW'(LOAD_LAT - 1);
    localparam logic [FRW-1:0]    FLUSH_RELOAD = FRW'(FLUSH_DEPTH - 1);
    localparam logic [0:0]        ST_IDLE      = 1'b0;
    localparam logic [0:0]        ST_STALL     = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [SRW-1:0]    stallRem_q, stallRem_d;
    logic [FRW-1:0]    flushRem_q, flushRem_d;
    logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0]  flushCnt_q, flushCnt_d;

    logic [1:0]        fwdA, fwdB;
    logic [DATA_W-1:0] aluA, aluB;
    logic              hazard, flushActive, stallCycle, flushCycle;
    logic              pcWrite, ifIdWrite, idExBubble, ifIdFlush;

    // EX/MEM result is younger than MEM/WB, so it wins when both match.
    function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src,
                                          input logic memWr, input logic [REG_AW-1:0] memRd,
                                          input logic wbWr, input logic [REG_AW-1:0] wbRd);
        fwdSel = 2'b00;
        if (memWr && memRd == src && memRd != ZERO)
            fwdSel = 2'b10;
        else if (wbWr && wbRd == src && wbRd != ZERO)
            fwdSel = 2'b01;
    endfunction

    always_comb begin
        fwdA = 2'b00;
        fwdB = 2'b00;
        if (reset_n_i) begin
            fwdA = fwdSel(bus.ex_rs, bus.mem_reg_write, bus.mem_rd, bus.wb_reg_write, bus.wb_rd);
            fwdB = fwdSel(bus.ex_rt, bus.mem_reg_write, bus.mem_rd, bus.wb_reg_write, bus.wb_rd);
        end
        case (fwdA)
            2'b10:   aluA = bus.mem_data;
            2'b01:   aluA = bus.wb_data;
            default: aluA = bus.ex_rs_data;
        endcase
        case (fwdB)
            2'b10:   aluB = bus.mem_data;
            2'b01:   aluB = bus.wb_data;
            default: aluB = bus.ex_rt_data;
        endcase
    end

    // A flush can only start from a branch, which also parks the stall FSM in IDLE,
    // so the flush-over-stall priority never leaves the FSM stuck in STALL.
    always_comb begin
        hazard      = bus.id_valid && bus.ex_mem_read && bus.ex_rd != ZERO &&
                      (bus.ex_rd == bus.id_rs || bus.ex_rd == bus.id_rt);
        flushActive = flushRem_q != '0;
        flushCycle  = bus.branch_taken || flushActive;
        stallCycle  = !flushCycle && ((state_q == ST_IDLE && hazard) || state_q == ST_STALL);

        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        idExBubble = 1'b0;
        ifIdFlush  = 1'b0;
        if (!reset_n_i) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExBubble = 1'b1;
            ifIdFlush  = 1'b1;
        end else if (flushCycle) begin
            ifIdWrite  = 1'b0;
            idExBubble = 1'b1;
            ifIdFlush  = 1'b1;
        end else if (stallCycle) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExBubble = 1'b1;
        end

        state_d    = state_q;
        stallRem_d = stallRem_q;
        flushRem_d = flushRem_q;
        if (bus.branch_taken) begin
            state_d    = ST_IDLE;
            stallRem_d = '0;
            flushRem_d = FLUSH_RELOAD;
        end else if (flushActive) begin
            flushRem_d = flushRem_q - FRW'(1);
        end else if (state_q == ST_STALL) begin
            if (stallRem_q == SRW'(1)) begin
                state_d    = ST_IDLE;
                stallRem_d = '0;
            end else begin
                stallRem_d = stallRem_q - SRW'(1);
            end
        end else if (hazard && LOAD_LAT > 1) begin
            state_d    = ST_STALL;
            stallRem_d = STALL_RELOAD;
        end

        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (stallCycle && stallCnt_q != '1)
            stallCnt_d = stallCnt_q + CNT_W'(1);
        if (flushCycle && flushCnt_q != '1)
            flushCnt_d = flushCnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            stallRem_q <= '0;
            flushRem_q <= '0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            stallRem_q <= stallRem_d;
            flushRem_q <= flushRem_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign bus.forward_a    = fwdA;
    assign bus.forward_b    = fwdB;
    assign bus.alu_in_a     = aluA;
    assign bus.alu_in_b     = aluB;
    assign bus.pc_write     = pcWrite;
    assign bus.if_id_write  = ifIdWrite;
    assign bus.id_ex_bubble = idExBubble;
    assign bus.if_id_flush  = ifIdFlush;
    assign bus.stall_cnt    = stallCnt_q;
    assign bus.flush_cnt    = flushCnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three instances (A: LOAD_LAT=1/FLUSH_DEPTH=2, B: LOAD_LAT=3/FLUSH_DEPTH=1,
// C: LOAD_LAT=1/CNT_W=2) share one stimulus stream.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic        idValid, exMemRead, memRegWrite, wbRegWrite, branchTaken;
    logic [3:0]  idRs, idRt, exRs, exRt, exRd, memRd, wbRd;
    logic [15:0] exRsData, exRtData, memData, wbData;

    logic [1:0]  fwdA [3];
    logic [1:0]  fwdB [3];
    logic [15:0] aluA [3];
    logic [15:0] aluB [3];
    logic        pcWrite [3];
    logic        ifIdWrite [3];
    logic        bubble [3];
    logic        flush [3];
    logic [15:0] stallCnt [3];
    logic [15:0] flushCnt [3];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 3; g++) begin : gDut
        localparam int LL = (g == 1) ? 3 : 1;
        localparam int FD = (g == 0) ? 2 : 1;
        localparam int CW = (g == 2) ? 2 : 16;

        pipeline_hazard_ctrl_if #(.DATA_W(16), .REG_AW(4), .CNT_W(CW)) bus ();

        assign bus.id_valid      = idValid;
        assign bus.id_rs         = idRs;
        assign bus.id_rt         = idRt;
        assign bus.ex_rs         = exRs;
        assign bus.ex_rt         = exRt;
        assign bus.ex_rd         = exRd;
        assign bus.ex_mem_read   = exMemRead;
        assign bus.ex_rs_data    = exRsData;
        assign bus.ex_rt_data    = exRtData;
        assign bus.mem_rd        = memRd;
        assign bus.mem_reg_write = memRegWrite;
        assign bus.mem_data      = memData;
        assign bus.wb_rd         = wbRd;
        assign bus.wb_reg_write  = wbRegWrite;
        assign bus.wb_data       = wbData;
        assign bus.branch_taken  = branchTaken;

        pipeline_hazard_ctrl #(
            .DATA_W(16), .REG_AW(4), .ZERO_REG(0),
            .LOAD_LAT(LL), .FLUSH_DEPTH(FD), .CNT_W(CW)
        ) dut (
            .clk_i     (clk),
            .reset_n_i (reset_n),
            .bus       (bus)
        );

        assign fwdA[g]      = bus.forward_a;
        assign fwdB[g]      = bus.forward_b;
        assign aluA[g]      = bus.alu_in_a;
        assign aluB[g]      = bus.alu_in_b;
        assign pcWrite[g]   = bus.pc_write;
        assign ifIdWrite[g] = bus.if_id_write;
        assign bubble[g]    = bus.id_ex_bubble;
        assign flush[g]     = bus.if_id_flush;
        assign stallCnt[g]  = 16'(bus.stall_cnt);
        assign flushCnt[g]  = 16'(bus.flush_cnt);
    end

    // Field order: exRs exRt memRd memRw wbRd wbRw idValid memRead exRd idRs idRt expFa expFb expA expB expStall
    typedef struct {
        logic [3:0]  exRs, exRt, memRd;
        logic        memRw;
        logic [3:0]  wbRd;
        logic        wbRw, idValid, memRead;
        logic [3:0]  exRd, idRs, idRt;
        logic [1:0]  expFa, expFb;
        logic [15:0] expA, expB;
        logic        expStall;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        idValid = 0; exMemRead = 0; memRegWrite = 0; wbRegWrite = 0; branchTaken = 0;
        idRs = 0; idRt = 0; exRs = 0; exRt = 0; exRd = 0; memRd = 0; wbRd = 0;
    endtask

    task automatic applyStimulus(input vec_t v);
        exRs = v.exRs; exRt = v.exRt; memRd = v.memRd; memRegWrite = v.memRw;
        wbRd = v.wbRd; wbRegWrite = v.wbRw; idValid = v.idValid; exMemRead = v.memRead;
        exRd = v.exRd; idRs = v.idRs; idRt = v.idRt; branchTaken = 0;
    endtask

    task automatic setLoadUse();
        idValid = 1; exMemRead = 1; exRd = 4'd5; idRs = 4'd5; idRt = 4'd1;
    endtask

    task automatic nextSlot();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        clearInputs();
        reset_n = 0;
        nextSlot();
        reset_n = 1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{4'd3, 4'd4, 4'd3, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd5, 4'd5, 4'd0, 2'b10, 2'b00, 16'h00AA, 16'h2222, 1'b0};
        vecs[1] = '{4'd3, 4'd3, 4'd3, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1, 4'd5, 4'd5, 4'd1, 2'b01, 2'b01, 16'h00BB, 16'h00BB, 1'b1};
        vecs[2] = '{4'd0, 4'd0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00, 16'h1111, 16'h2222, 1'b0};
        vecs[3] = '{4'd5, 4'd6, 4'd6, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 4'd5, 4'd5, 4'd5, 2'b01, 2'b10, 16'h00BB, 16'h00AA, 1'b0};
        vecs[4] = '{4'd7, 4'd7, 4'd7, 1'b0, 4'd7, 1'b0, 1'b1, 1'b1, 4'd8, 4'd1, 4'd8, 2'b00, 2'b00, 16'h1111, 16'h2222, 1'b1};
        vecs[5] = '{4'd9, 4'd2, 4'd2, 1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 4'd8, 4'd1, 4'd2, 2'b00, 2'b10, 16'h1111, 16'h00AA, 1'b0};

        exRsData = 16'h1111; exRtData = 16'h2222; memData = 16'h00AA; wbData = 16'h00BB;
        clearInputs();
        reset_n = 0;

        // Outputs while held in reset, with a forwarding match present
        exRs = 4'd3; memRd = 4'd3; memRegWrite = 1;
        #2;
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("rst pc_write[%0d]", g), 32'(pcWrite[g]), 32'd0);
            checkOutput($sformatf("rst if_id_flush[%0d]", g), 32'(flush[g]), 32'd1);
        end
        checkOutput("rst if_id_write", 32'(ifIdWrite[0]), 32'd0);
        checkOutput("rst id_ex_bubble", 32'(bubble[0]), 32'd1);
        checkOutput("rst forward_a", 32'(fwdA[0]), 32'd0);
        nextSlot();
        reset_n = 1;
        clearInputs();
        #1;
        checkOutput("post-rst pc_write", 32'(pcWrite[0]), 32'd1);
        checkOutput("post-rst if_id_flush", 32'(flush[0]), 32'd0);
        checkOutput("post-rst stall_cnt", 32'(stallCnt[0]), 32'd0);
        checkOutput("post-rst flush_cnt", 32'(flushCnt[0]), 32'd0);
        nextSlot();

        // Table: forwarding and single-cycle load-use detect on instance A
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d forward_a", i), 32'(fwdA[0]), 32'(vecs[i].expFa));
            checkOutput($sformatf("vec%0d forward_b", i), 32'(fwdB[0]), 32'(vecs[i].expFb));
            checkOutput($sformatf("vec%0d alu_in_a", i), 32'(aluA[0]), 32'(vecs[i].expA));
            checkOutput($sformatf("vec%0d alu_in_b", i), 32'(aluB[0]), 32'(vecs[i].expB));
            checkOutput($sformatf("vec%0d pc_write", i), 32'(pcWrite[0]), 32'(!vecs[i].expStall));
            checkOutput($sformatf("vec%0d if_id_write", i), 32'(ifIdWrite[0]), 32'(!vecs[i].expStall));
            checkOutput($sformatf("vec%0d id_ex_bubble", i), 32'(bubble[0]), 32'(vecs[i].expStall));
            nextSlot();
        end

        // LOAD_LAT=1: exactly one stall cycle
        applyReset();
        setLoadUse();
        #1;
        checkOutput("ll1 pc_write", 32'(pcWrite[0]), 32'd0);
        checkOutput("ll1 id_ex_bubble", 32'(bubble[0]), 32'd1);
        nextSlot();
        clearInputs();
        #1;
        checkOutput("ll1 release pc_write", 32'(pcWrite[0]), 32'd1);
        checkOutput("ll1 release bubble", 32'(bubble[0]), 32'd0);
        checkOutput("ll1 stall_cnt", 32'(stallCnt[0]), 32'd1);

        // LOAD_LAT=3: three stall cycles, hazard dropped after the first
        applyReset();
        setLoadUse();
        for (int k = 0; k < 4; k++) begin
            if (k == 1) clearInputs();
            #1;
            checkOutput($sformatf("ll3 cyc%0d pc_write", k), 32'(pcWrite[1]), 32'(k == 3));
            checkOutput($sformatf("ll3 cyc%0d bubble", k), 32'(bubble[1]), 32'(k != 3));
            nextSlot();
        end
        checkOutput("ll3 stall_cnt", 32'(stallCnt[1]), 32'd3);

        // Flush with restart: A (depth 2) and B (depth 1)
        applyReset();
        branchTaken = 1;
        #1;
        checkOutput("br0 A if_id_flush", 32'(flush[0]), 32'd1);
        checkOutput("br0 A pc_write", 32'(pcWrite[0]), 32'd1);
        checkOutput("br0 A if_id_write", 32'(ifIdWrite[0]), 32'd0);
        checkOutput("br0 A bubble", 32'(bubble[0]), 32'd1);
        nextSlot();
        #1;
        checkOutput("br1 A if_id_flush", 32'(flush[0]), 32'd1);
        checkOutput("br1 B if_id_flush", 32'(flush[1]), 32'd1);
        nextSlot();
        branchTaken = 0;
        #1;
        checkOutput("br2 A if_id_flush", 32'(flush[0]), 32'd1);
        checkOutput("br2 A bubble", 32'(bubble[0]), 32'd1);
        checkOutput("br2 B if_id_flush", 32'(flush[1]), 32'd0);
        nextSlot();
        #1;
        checkOutput("br3 A if_id_flush", 32'(flush[0]), 32'd0);
        checkOutput("br3 A pc_write", 32'(pcWrite[0]), 32'd1);
        checkOutput("br3 A flush_cnt", 32'(flushCnt[0]), 32'd3);
        checkOutput("br3 B flush_cnt", 32'(flushCnt[1]), 32'd2);

        // Branch in second stall cycle aborts the stall (B)
        applyReset();
        setLoadUse();
        #1;
        checkOutput("abort s0 pc_write", 32'(pcWrite[1]), 32'd0);
        checkOutput("abort s0 if_id_flush", 32'(flush[1]), 32'd0);
        nextSlot();
        clearInputs();
        branchTaken = 1;
        #1;
        checkOutput("abort s1 pc_write", 32'(pcWrite[1]), 32'd1);
        checkOutput("abort s1 if_id_flush", 32'(flush[1]), 32'd1);
        checkOutput("abort s1 if_id_write", 32'(ifIdWrite[1]), 32'd0);
        nextSlot();
        branchTaken = 0;
        #1;
        checkOutput("abort s2 pc_write", 32'(pcWrite[1]), 32'd1);
        checkOutput("abort s2 bubble", 32'(bubble[1]), 32'd0);
        checkOutput("abort s2 if_id_flush", 32'(flush[1]), 32'd0);
        checkOutput("abort stall_cnt", 32'(stallCnt[1]), 32'd1);
        checkOutput("abort flush_cnt", 32'(flushCnt[1]), 32'd1);

        // Reset mid-stall (B)
        applyReset();
        setLoadUse();
        nextSlot();
        clearInputs();
        #1;
        checkOutput("midstall pre stall_cnt", 32'(stallCnt[1]), 32'd1);
        reset_n = 0;
        #1;
        checkOutput("midstall rst stall_cnt", 32'(stallCnt[1]), 32'd0);
        checkOutput("midstall rst pc_write", 32'(pcWrite[1]), 32'd0);
        nextSlot();
        reset_n = 1;
        #1;
        checkOutput("midstall post pc_write", 32'(pcWrite[1]), 32'd1);
        checkOutput("midstall post bubble", 32'(bubble[1]), 32'd0);
        nextSlot();
        checkOutput("midstall post2 stall_cnt", 32'(stallCnt[1]), 32'd0);

        // Reset mid-flush (A)
        applyReset();
        branchTaken = 1;
        nextSlot();
        branchTaken = 0;
        #1;
        checkOutput("midflush pre if_id_flush", 32'(flush[0]), 32'd1);
        reset_n = 0;
        #1;
        checkOutput("midflush rst flush_cnt", 32'(flushCnt[0]), 32'd0);
        nextSlot();
        reset_n = 1;
        #1;
        checkOutput("midflush post if_id_flush", 32'(flush[0]), 32'd0);
        checkOutput("midflush post pc_write", 32'(pcWrite[0]), 32'd1);

        // Counter saturation: five stalls on CNT_W=2 (C) vs CNT_W=16 (A)
        applyReset();
        setLoadUse();
        repeat (5) nextSlot();
        clearInputs();
        #1;
        checkOutput("sat C stall_cnt", 32'(stallCnt[2]), 32'd3);
        checkOutput("sat A stall_cnt", 32'(stallCnt[0]), 32'd5);
        nextSlot();
        checkOutput("sat C hold stall_cnt", 32'(stallCnt[2]), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
